// File: rtl/life_pkg.sv
// life_pkg: shared sizes and controller state encoding for the 4x4 life sequencer.
package life_pkg;

  localparam int CELLS    = 16;  // 4x4 array, bit index 4*row+col
  localparam int PERIOD_W = 24;  // generation-period input and wait counter width
  localparam int GEN_W    = 16;  // saturating generation counter width

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_LOAD   = 3'd1,
    ST_WAIT   = 3'd2,
    ST_STEP   = 3'd3,
    ST_SETTLE = 3'd4,
    ST_CHECK  = 3'd5,
    ST_HALTED = 3'd6
  } state_t;

endpackage

// File: rtl/life_period_timer.sv
// life_period_timer: loadable down-counter pacing the idle gap between generations.
// A reload value of zero is treated as one so free-run never stalls.
module life_period_timer
  import life_pkg::*;
#(
  parameter int W = PERIOD_W
) (
  input  logic         clk,
  input  logic         i_reset,       // asynchronous, active-low
  input  logic         i_load,
  input  logic [W-1:0] i_load_value,
  input  logic         i_clear,
  input  logic         i_dec,
  output logic         o_tc
);

  logic [W-1:0] r_count;
  logic [W-1:0] w_reload;

  assign w_reload = (i_load_value == '0) ? W'(1) : i_load_value;

  // Count register: clear wins over reload, reload over decrement; never wraps below zero.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_count <= '0;
    end else if (i_clear) begin
      r_count <= '0;
    end else if (i_load) begin
      r_count <= w_reload;
    end else if (i_dec && (r_count != '0)) begin
      r_count <= r_count - W'(1);
    end
  end

  // Terminal count: the last waiting cycle before a step is issued.
  assign o_tc = (r_count == W'(1));

endmodule

// File: rtl/life_gen_controller.sv
// life_gen_controller: loads seed patterns into the 4x4 life array, paces generation
// steps, and classifies each new generation as extinct, still life or period-2.
module life_gen_controller
  import life_pkg::*;
(
  input  logic                clk,
  input  logic                i_reset,          // asynchronous, active-low
  input  logic                i_load_valid,
  output logic                o_load_ready,
  input  logic [CELLS-1:0]    i_load_pattern,
  input  logic                i_run,
  input  logic                i_single,
  input  logic [PERIOD_W-1:0] i_period,
  input  logic                i_halt_on_stable,
  input  logic [CELLS-1:0]    i_alive,
  input  logic [CELLS-1:0]    i_alive_prev,
  output logic [CELLS-1:0]    o_val,
  output logic                o_write_enb,
  output logic                o_step,
  output logic [GEN_W-1:0]    o_gen_count,
  output logic                o_extinct,
  output logic                o_stable,
  output logic                o_osc2,
  output logic                o_busy
);

  state_t           r_state;
  state_t           w_state_next;
  logic [CELLS-1:0] r_val;
  logic [CELLS-1:0] r_snapshot;     // alive_prev at the last check = generation two back
  logic [GEN_W-1:0] r_gen_count;
  logic             r_extinct;
  logic             r_stable;
  logic             r_osc2;

  logic             w_accept;
  logic             w_timer_load;
  logic             w_timer_clear;
  logic             w_timer_dec;
  logic             w_timer_tc;
  logic [GEN_W-1:0] w_gen_inc;
  logic             w_extinct;
  logic             w_stable;
  logic             w_osc2;
  logic             w_any_flag;

  life_period_timer #(
    .W(PERIOD_W)
  ) u_timer (
    .clk         (clk),
    .i_reset     (i_reset),
    .i_load      (w_timer_load),
    .i_load_value(i_period),
    .i_clear     (w_timer_clear),
    .i_dec       (w_timer_dec),
    .o_tc        (w_timer_tc)
  );

  // Classification of the generation currently presented by the array.
  assign w_gen_inc  = (r_gen_count == {GEN_W{1'b1}}) ? r_gen_count : r_gen_count + GEN_W'(1);
  assign w_extinct  = (i_alive == '0);
  assign w_stable   = (i_alive == i_alive_prev);
  assign w_osc2     = (i_alive == r_snapshot) && !w_stable && (w_gen_inc >= GEN_W'(2));
  assign w_any_flag = w_extinct | w_stable | w_osc2;

  // State register; reset forces IDLE so step/write_enb drop at once.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_next;
    end
  end

  // Next-state, strobes and timer control; a load always beats run/single.
  always_comb begin
    w_state_next  = r_state;
    w_accept      = 1'b0;
    w_timer_load  = 1'b0;
    w_timer_clear = 1'b0;
    w_timer_dec   = 1'b0;
    o_load_ready  = 1'b0;
    o_write_enb   = 1'b0;
    o_step        = 1'b0;
    o_busy        = 1'b1;
    case (r_state)
      ST_IDLE: begin
        o_load_ready = 1'b1;
        o_busy       = 1'b0;
        if (i_load_valid) begin
          w_accept      = 1'b1;
          w_timer_clear = 1'b1;
          w_state_next  = ST_LOAD;
        end else if (i_run) begin
          w_timer_load = 1'b1;
          w_state_next = ST_WAIT;
        end else if (i_single) begin
          w_state_next = ST_STEP;
        end
      end
      ST_LOAD: begin
        o_write_enb  = 1'b1;
        w_state_next = ST_IDLE;
      end
      ST_WAIT: begin
        o_load_ready = 1'b1;
        if (i_load_valid) begin
          w_accept      = 1'b1;
          w_timer_clear = 1'b1;
          w_state_next  = ST_LOAD;
        end else if (!i_run) begin
          w_timer_clear = 1'b1;
          w_state_next  = ST_IDLE;
        end else if (w_timer_tc) begin
          w_state_next = ST_STEP;
        end else begin
          w_timer_dec = 1'b1;
        end
      end
      ST_STEP: begin
        o_step       = 1'b1;
        w_state_next = ST_SETTLE;
      end
      ST_SETTLE: begin
        w_state_next = ST_CHECK;
      end
      ST_CHECK: begin
        if (i_halt_on_stable && w_any_flag) begin
          w_state_next = ST_HALTED;
        end else if (i_run) begin
          w_timer_load = 1'b1;
          w_state_next = ST_WAIT;
        end else begin
          w_state_next = ST_IDLE;
        end
      end
      ST_HALTED: begin
        o_load_ready = 1'b1;
        o_busy       = 1'b0;
        if (i_load_valid) begin
          w_accept      = 1'b1;
          w_timer_clear = 1'b1;
          w_state_next  = ST_LOAD;
        end else if (!i_run) begin
          w_state_next = ST_IDLE;
        end
      end
      default: begin
        w_state_next = ST_IDLE;
      end
    endcase
  end

  // Seed pattern, generation counter, flags and two-back snapshot.
  always_ff @(posedge clk or negedge i_reset) begin
    if (!i_reset) begin
      r_val       <= '0;
      r_snapshot  <= '0;
      r_gen_count <= '0;
      r_extinct   <= 1'b0;
      r_stable    <= 1'b0;
      r_osc2      <= 1'b0;
    end else if (w_accept) begin
      r_val       <= i_load_pattern;
      r_snapshot  <= '0;
      r_gen_count <= '0;
      r_extinct   <= 1'b0;
      r_stable    <= 1'b0;
      r_osc2      <= 1'b0;
    end else if (r_state == ST_CHECK) begin
      r_gen_count <= w_gen_inc;
      r_extinct   <= w_extinct;
      r_stable    <= w_stable;
      r_osc2      <= w_osc2;
      r_snapshot  <= i_alive_prev;
    end
  end

  assign o_val       = r_val;
  assign o_gen_count = r_gen_count;
  assign o_extinct   = r_extinct;
  assign o_stable    = r_stable;
  assign o_osc2      = r_osc2;

endmodule

// File: tb/tb_life_gen_controller.sv
// tb_life_gen_controller: drives the controller against a behavioural 4x4 life array
// and compares step timing and generation classification with a reference model.
module tb_life_gen_controller;
  import life_pkg::*;

  logic                clk = 1'b0;
  logic                rst_n;
  logic                load_valid;
  logic                load_ready;
  logic [CELLS-1:0]    load_pattern;
  logic                run;
  logic                single;
  logic [PERIOD_W-1:0] period;
  logic                halt_on_stable;
  logic [CELLS-1:0]    alive;
  logic [CELLS-1:0]    alive_prev;
  logic [CELLS-1:0]    val;
  logic                write_enb;
  logic                step;
  logic [GEN_W-1:0]    gen_count;
  logic                extinct;
  logic                stable;
  logic                osc2;
  logic                busy;

  int n_checks = 0;
  int n_pass   = 0;
  int cyc      = 0;
  int viol_consec  = 0;
  int viol_overlap = 0;

  typedef struct {
    int               at;
    logic [CELLS-1:0] alv;
    logic [GEN_W-1:0] gen;
    logic             ext;
    logic             stab;
    logic             osc;
  } rec_t;

  rec_t recs[$];
  int   steps[$];
  logic [2:0] step_d;

  always #5 clk = ~clk;

  life_gen_controller dut (
    .clk             (clk),
    .i_reset         (rst_n),
    .i_load_valid    (load_valid),
    .o_load_ready    (load_ready),
    .i_load_pattern  (load_pattern),
    .i_run           (run),
    .i_single        (single),
    .i_period        (period),
    .i_halt_on_stable(halt_on_stable),
    .i_alive         (alive),
    .i_alive_prev    (alive_prev),
    .o_val           (val),
    .o_write_enb     (write_enb),
    .o_step          (step),
    .o_gen_count     (gen_count),
    .o_extinct       (extinct),
    .o_stable        (stable),
    .o_osc2          (osc2),
    .o_busy          (busy)
  );

  // Conway rule on a 4x4 board with dead cells outside the edges.
  function automatic logic [CELLS-1:0] life_next(input logic [CELLS-1:0] p);
    logic [CELLS-1:0] n;
    int cnt;
    n = '0;
    for (int r = 0; r < 4; r++) begin
      for (int c = 0; c < 4; c++) begin
        cnt = 0;
        for (int dr = -1; dr <= 1; dr++) begin
          for (int dc = -1; dc <= 1; dc++) begin
            if (!(dr == 0 && dc == 0) && (r + dr >= 0) && (r + dr < 4) &&
                (c + dc >= 0) && (c + dc < 4)) begin
              cnt += int'(p[4 * (r + dr) + c + dc]);
            end
          end
        end
        n[4 * r + c] = (cnt == 3) || (p[4 * r + c] && cnt == 2);
      end
    end
    return n;
  endfunction

  // Behavioural life array: write loads a pattern, step advances one generation.
  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      alive      <= '0;
      alive_prev <= '0;
    end else if (write_enb) begin
      alive      <= val;
      alive_prev <= val;
    end else if (step) begin
      alive_prev <= alive;
      alive      <= life_next(alive);
    end
  end

  always @(posedge clk) cyc <= cyc + 1;

  // Recorder: step times, and the visible result three cycles after each step.
  always @(negedge clk) begin
    if (!rst_n) begin
      step_d <= '0;
    end else begin
      if (step && step_d[0]) viol_consec <= viol_consec + 1;
      if (step && write_enb) viol_overlap <= viol_overlap + 1;
      if (step) steps.push_back(cyc);
      if (step_d[2]) recs.push_back('{cyc, alive, gen_count, extinct, stable, osc2});
      step_d <= {step_d[1:0], step};
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic go_idle();
    run        = 1'b0;
    single     = 1'b0;
    load_valid = 1'b0;
    tick(6);
  endtask

  task automatic do_load(input logic [CELLS-1:0] p);
    int t;
    t = 0;
    while (load_ready !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    load_valid   = 1'b1;
    load_pattern = p;
    tick(1);
    load_valid   = 1'b0;
  endtask

  task automatic wait_recs(input int target, input int bound, output bit ok);
    int t;
    t = 0;
    while (recs.size() < target && t < bound) begin
      tick(1);
      t++;
    end
    ok = (recs.size() >= target);
  endtask

  task automatic test_reset();
    logic [CELLS+GEN_W+7:0] got;
    rst_n = 1'b0;
    tick(2);
    got = {val, gen_count, write_enb, step, extinct, stable, osc2, busy, load_ready, 1'b0};
    n_checks++;
    if (got !== {{(CELLS+GEN_W+6){1'b0}}, 1'b1, 1'b0})
      $display("FAIL reset_state: got %h required %h", got, {{(CELLS+GEN_W+6){1'b0}}, 1'b1, 1'b0});
    else n_pass++;
    #3 rst_n = 1'b1;
    tick(1);
    n_checks++;
    if ({load_ready, busy} !== 2'b10)
      $display("FAIL reset_release: ready/busy got %b required 10", {load_ready, busy});
    else n_pass++;
  endtask

  task automatic test_load();
    int sb;
    go_idle();
    sb = steps.size();
    load_valid = 1'b1;
    single = 1'b1;
    load_pattern = 16'h0070;
    tick(1);
    load_valid = 1'b0;
    single = 1'b0;
    $display("load pattern=0070");
    n_checks++;
    if ({write_enb, val, load_ready, busy} !== {1'b1, 16'h0070, 1'b0, 1'b1})
      $display("FAIL load_strobe: we/val/ready/busy got %b/%h/%b/%b required 1/0070/0/1",
               write_enb, val, load_ready, busy);
    else n_pass++;
    tick(1);
    n_checks++;
    if ({write_enb, val, alive, gen_count} !== {1'b0, 16'h0070, 16'h0070, 16'h0000})
      $display("FAIL load_after: we/val/alive/gen got %b/%h/%h/%0d required 0/0070/0070/0",
               write_enb, val, alive, gen_count);
    else n_pass++;
    tick(5);
    n_checks++;
    if ({write_enb, val, 8'(steps.size() - sb)} !== {1'b0, 16'h0070, 8'd0})
      $display("FAIL load_single_dropped: we/val/steps got %b/%h/%0d required 0/0070/0",
               write_enb, val, steps.size() - sb);
    else n_pass++;
  endtask

  task automatic test_blinker();
    int rb, sb;
    bit ok;
    logic [CELLS-1:0] exp_alv [0:2];
    exp_alv[0] = 16'h0222;
    exp_alv[1] = 16'h0070;
    exp_alv[2] = 16'h0222;
    go_idle();
    rb = recs.size();
    sb = steps.size();
    period = 24'd4;
    halt_on_stable = 1'b0;
    do_load(16'h0070);
    run = 1'b1;
    wait_recs(rb + 3, 60, ok);
    n_checks++;
    if (!ok) $display("FAIL blinker_timeout: got %0d gens required 3", recs.size() - rb);
    else n_pass++;
    if (ok) begin
      for (int k = 0; k < 3; k++) begin
        $display("blinker gen=%0d alive=%h stable=%b osc2=%b", recs[rb+k].gen,
                 recs[rb+k].alv, recs[rb+k].stab, recs[rb+k].osc);
        n_checks++;
        if ({recs[rb+k].alv, recs[rb+k].gen, recs[rb+k].stab, recs[rb+k].osc} !==
            {exp_alv[k], GEN_W'(k + 1), 1'b0, (k >= 1) ? 1'b1 : 1'b0})
          $display("FAIL blinker_gen%0d: alive/gen/stable/osc2 got %h/%0d/%b/%b required %h/%0d/0/%b",
                   k + 1, recs[rb+k].alv, recs[rb+k].gen, recs[rb+k].stab, recs[rb+k].osc,
                   exp_alv[k], k + 1, (k >= 1));
        else n_pass++;
      end
      for (int k = 1; k < 3; k++) begin
        n_checks++;
        if (steps[sb+k] - steps[sb+k-1] !== 7)
          $display("FAIL blinker_spacing: got %0d required 7", steps[sb+k] - steps[sb+k-1]);
        else n_pass++;
      end
    end
    run = 1'b0;
  endtask

  task automatic test_halt_block();
    int rb, sb, pe;
    bit ok;
    go_idle();
    rb = recs.size();
    sb = steps.size();
    pe = $urandom_range(1, 4);
    period = PERIOD_W'(pe);
    halt_on_stable = 1'b1;
    do_load(16'h0660);
    run = 1'b1;
    wait_recs(rb + 1, 40, ok);
    $display("block period=%0d gens=%0d", pe, recs.size() - rb);
    n_checks++;
    if (!ok || {recs[rb].stab, recs[rb].gen, busy} !== {1'b1, 16'd1, 1'b0})
      $display("FAIL halt_block: ok/stable/gen/busy got %b/%b/%0d/%b required 1/1/1/0",
               ok, recs[rb].stab, recs[rb].gen, busy);
    else n_pass++;
    tick(2 * (pe + 3) + 4);
    single = 1'b1;
    tick(1);
    single = 1'b0;
    tick(6);
    n_checks++;
    if ({8'(steps.size() - sb), gen_count, busy, load_ready} !== {8'd1, 16'd1, 1'b0, 1'b1})
      $display("FAIL halt_hold: steps/gen/busy/ready got %0d/%0d/%b/%b required 1/1/0/1",
               steps.size() - sb, gen_count, busy, load_ready);
    else n_pass++;
    run = 1'b0;
    halt_on_stable = 1'b0;
  endtask

  task automatic test_single();
    int rb, sb;
    bit ok;
    go_idle();
    rb = recs.size();
    sb = steps.size();
    do_load(16'h0001);
    tick(1);
    single = 1'b1;
    tick(1);
    single = 1'b0;
    wait_recs(rb + 1, 10, ok);
    $display("single seed=0001 gens=%0d", recs.size() - rb);
    n_checks++;
    if (!ok || {recs[rb].alv, recs[rb].ext, recs[rb].gen} !== {16'h0000, 1'b1, 16'd1})
      $display("FAIL single_result: ok/alive/extinct/gen got %b/%h/%b/%0d required 1/0000/1/1",
               ok, recs[rb].alv, recs[rb].ext, recs[rb].gen);
    else n_pass++;
    tick(8);
    n_checks++;
    if ({8'(steps.size() - sb), busy} !== {8'd1, 1'b0})
      $display("FAIL single_once: steps/busy got %0d/%b required 1/0", steps.size() - sb, busy);
    else n_pass++;
  endtask

  task automatic test_reload_in_wait();
    int rb, sb, pe, h_cyc;
    bit ok;
    go_idle();
    rb = recs.size();
    sb = steps.size();
    pe = $urandom_range(3, 8);
    period = PERIOD_W'(pe);
    halt_on_stable = 1'b0;
    do_load(16'h0070);
    run = 1'b1;
    wait_recs(rb + 3, 3 * (pe + 3) + 20, ok);
    n_checks++;
    if (!ok || gen_count !== 16'd3)
      $display("FAIL reload_pre: ok/gen got %b/%0d required 1/3", ok, gen_count);
    else n_pass++;
    h_cyc = cyc;
    load_valid = 1'b1;
    load_pattern = 16'hCC33;
    tick(1);
    load_valid = 1'b0;
    $display("reload pattern=cc33 period=%0d", pe);
    n_checks++;
    if ({write_enb, gen_count, extinct, stable, osc2} !== {1'b1, 16'd0, 3'b000})
      $display("FAIL reload_clear: we/gen/flags got %b/%0d/%b required 1/0/000",
               write_enb, gen_count, {extinct, stable, osc2});
    else n_pass++;
    wait_recs(rb + 4, pe + 12, ok);
    n_checks++;
    if (!ok || steps[sb+3] !== h_cyc + pe + 3)
      $display("FAIL reload_resume: ok/step_at got %b/%0d required 1/%0d", ok, steps[sb+3],
               h_cyc + pe + 3);
    else n_pass++;
    n_checks++;
    if (!ok || {recs[rb+3].alv, recs[rb+3].gen} !== {16'hC813, 16'd1})
      $display("FAIL reload_gen1: alive/gen got %h/%0d required c813/1", recs[rb+3].alv,
               recs[rb+3].gen);
    else n_pass++;
    run = 1'b0;
  endtask

  task automatic test_random_runs();
    logic [CELLS-1:0] hist [0:6];
    bit e [1:6];
    bit s [1:6];
    bit o [1:6];
    logic [CELLS-1:0] seed;
    logic [CELLS+GEN_W+2:0] got_v, exp_v;
    int p, pe, exp_n, rb, sb, r_cyc;
    bit h, found, ok;
    for (int it = 0; it < 8; it++) begin
      seed = CELLS'($urandom_range(0, 65535));
      p = $urandom_range(0, 5);
      pe = (p == 0) ? 1 : p;
      h = 1'($urandom_range(0, 1));
      hist[0] = seed;
      for (int k = 1; k <= 6; k++) begin
        hist[k] = life_next(hist[k-1]);
        e[k] = (hist[k] == '0);
        s[k] = (hist[k] == hist[k-1]);
        o[k] = (k >= 2) && (hist[k] == hist[k-2]) && !s[k];
      end
      exp_n = 6;
      found = 1'b0;
      for (int k = 1; k <= 6; k++) begin
        if (!found && h && (e[k] || s[k] || o[k])) begin
          exp_n = k;
          found = 1'b1;
        end
      end
      go_idle();
      rb = recs.size();
      sb = steps.size();
      period = PERIOD_W'(p);
      halt_on_stable = h;
      do_load(seed);
      tick(1);
      run = 1'b1;
      r_cyc = cyc;
      wait_recs(rb + exp_n, exp_n * (pe + 3) + 20, ok);
      $display("random run=%0d seed=%h period=%0d halt=%0d gens=%0d", it, seed, p, h, exp_n);
      n_checks++;
      if (!ok) $display("FAIL rand%0d_timeout: got %0d gens required %0d", it, recs.size() - rb, exp_n);
      else n_pass++;
      if (ok) begin
        for (int k = 1; k <= exp_n; k++) begin
          exp_v = {hist[k], GEN_W'(k), e[k], s[k], o[k]};
          got_v = {recs[rb+k-1].alv, recs[rb+k-1].gen, recs[rb+k-1].ext,
                   recs[rb+k-1].stab, recs[rb+k-1].osc};
          n_checks++;
          if (got_v !== exp_v)
            $display("FAIL rand%0d_gen%0d: alive/gen/flags got %h required %h", it, k, got_v, exp_v);
          else n_pass++;
          n_checks++;
          if (steps[sb+k-1] !== r_cyc + pe + 1 + (k - 1) * (pe + 3))
            $display("FAIL rand%0d_step%0d_time: got %0d required %0d", it, k, steps[sb+k-1],
                     r_cyc + pe + 1 + (k - 1) * (pe + 3));
          else n_pass++;
        end
      end
      if (found) begin
        tick(2 * (pe + 3) + 4);
        n_checks++;
        if ({8'(steps.size() - sb), busy} !== {8'(exp_n), 1'b0})
          $display("FAIL rand%0d_halted: steps/busy got %0d/%b required %0d/0", it,
                   steps.size() - sb, busy, exp_n);
        else n_pass++;
      end
      run = 1'b0;
    end
    halt_on_stable = 1'b0;
  endtask

  task automatic test_reset_mid_op();
    int rb, t;
    bit ok;
    logic [CELLS+GEN_W+5:0] got;
    go_idle();
    rb = recs.size();
    period = 24'd10;
    halt_on_stable = 1'b0;
    do_load(16'h0070);
    run = 1'b1;
    wait_recs(rb + 2, 40, ok);
    tick(2);
    #3 rst_n = 1'b0;
    run = 1'b0;
    #1;
    got = {step, write_enb, busy, gen_count, extinct, stable, osc2, val};
    $display("reset asserted mid-wait");
    n_checks++;
    if (!ok || got !== '0)
      $display("FAIL reset_mid_wait: ok/outputs got %b/%h required 1/0", ok, got);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(1);
    n_checks++;
    if ({load_ready, busy} !== 2'b10)
      $display("FAIL reset_mid_release: ready/busy got %b required 10", {load_ready, busy});
    else n_pass++;
    period = 24'd1;
    do_load(16'h0070);
    run = 1'b1;
    t = 0;
    while (step !== 1'b1 && t < 20) begin
      tick(1);
      t++;
    end
    #2 rst_n = 1'b0;
    run = 1'b0;
    #1;
    n_checks++;
    if (t >= 20 || step !== 1'b0)
      $display("FAIL reset_truncate: wait/step got %0d/%b required <20/0", t, step);
    else n_pass++;
    @(negedge clk);
    rst_n = 1'b1;
    tick(2);
  endtask

  task automatic test_invariants();
    n_checks++;
    if (viol_consec !== 0 || viol_overlap !== 0)
      $display("FAIL strobe_invariants: consecutive/overlap got %0d/%0d required 0/0",
               viol_consec, viol_overlap);
    else n_pass++;
  endtask

  initial begin
    load_valid     = 1'b0;
    load_pattern   = '0;
    run            = 1'b0;
    single         = 1'b0;
    period         = '0;
    halt_on_stable = 1'b0;
    test_reset();
    test_load();
    test_blinker();
    test_halt_block();
    test_single();
    test_reload_in_wait();
    test_random_runs();
    test_reset_mid_op();
    test_invariants();
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/life_gen_controller.md
Name: life_gen_controller

Overview:
- Sequencer that sits directly in front of the 4x4 life array.
- Accepts seed patterns over a valid/ready handshake and drives the array's val/write_enb.
- Issues single-cycle step pulses at a programmable generation period, or on single-step request.
- Reads back alive/alive_prev to count generations and flag extinction, still life and period-2 oscillation, with optional auto-halt.

Parameters:
CELLS, 16, number of cells in the array (4x4); width of pattern/alive buses
PERIOD_W, 24, width of the generation-period input and wait counter
GEN_W, 16, width of the generation counter

Ports:
clk  in  1  system clock, all logic on rising edge
reset  in  1  asynchronous, active-low; 0 clears all state immediately
load_valid  in  1  seed pattern offered
load_ready  out  1  controller can accept a seed this cycle
load_pattern  in  CELLS  seed pattern (bit 4*row+col)
run  in  1  level; 1 = free-run generations
single  in  1  one-cycle request for exactly one generation
period  in  PERIOD_W  idle cycles between generations; 0 treated as 1
halt_on_stable  in  1  1 = stop on extinct/stable/osc2
alive  in  CELLS  current generation from array
alive_prev  in  CELLS  previous generation from array
val  out  CELLS  pattern to array
write_enb  out  1  one-cycle write strobe to array
step  out  1  one-cycle advance strobe to array
gen_count  out  GEN_W  generations since last load, saturating
extinct  out  1  alive == 0 at last check
stable  out  1  alive == alive_prev at last check
osc2  out  1  alive equals the generation two back, and not stable
busy  out  1  1 in any state except IDLE/HALTED

Behaviour:
- Reset (reset=0): state IDLE; val=0, write_enb=0, step=0, gen_count=0, extinct/stable/osc2=0, busy=0, wait counter=0, two-back snapshot=0. load_ready=1 in IDLE.
- States: IDLE, LOAD, WAIT, STEP, SETTLE, CHECK, HALTED.
- load_ready=1 in IDLE, WAIT, HALTED; 0 in LOAD, STEP, SETTLE, CHECK.
- Load handshake: transfer when load_valid & load_ready at a rising edge.
  - val <= load_pattern; go to LOAD.
  - gen_count, flags and snapshot cleared; wait counter cleared.
- LOAD: write_enb=1 for exactly this one cycle, then to IDLE. val holds the pattern until the next load.
- IDLE:
  - run=1 -> WAIT with counter = max(period,1).
  - Else single=1 -> STEP.
  - Load has priority over run/single in the same cycle; a single request coinciding with a load is dropped.
- WAIT:
  - Counter decrements; at 1 -> STEP.
  - run=0 -> IDLE, counter cleared.
  - A period change takes effect at the next reload only.
- STEP: step=1 for one cycle.
- SETTLE: one cycle for the array register to update.
- CHECK (alive valid):
  - gen_count += 1, saturating at all-ones.
  - extinct = (alive==0); stable = (alive==alive_prev); osc2 = (alive==snapshot) & ~stable & (gen_count>=2 after increment).
  - snapshot <= alive_prev.
  - If halt_on_stable and any flag set -> HALTED; else run ? WAIT (reload) : IDLE.
- Step spacing in free-run = period + 3 cycles.
- HALTED: no steps. Leaves on load (-> LOAD) or run=0 (-> IDLE); single is ignored.
- step is never high on two consecutive cycles; write_enb and step are never high together.
- Reset mid-operation: outputs drop asynchronously; a pulse in flight is truncated.

Decomposition:
- Shared package life_pkg: CELLS, GEN_W, PERIOD_W, state enum constants.
- One natural sub-module, life_period_timer: loadable down-counter with a terminal-count flag, used for WAIT.
- Flag compare stays inline.

Test Plan:
1. reset=0 mid-WAIT with run=1 -> step/write_enb=0 immediately, gen_count=0; after release load_ready=1, busy=0.
2. Load 0x0070 (valid 1 cycle) -> next cycle write_enb=1 and val=0x0070 for exactly one cycle; array alive=0x0070; gen_count=0.
3. Blinker 0x0070, run=1, period=4 -> step pulses 7 cycles apart; alive alternates 0x0222/0x0070; gen_count 1,2,3; osc2=1 from gen 2, stable=0.
4. Block 0x0660, halt_on_stable=1, run=1 -> after gen 1 stable=1, HALTED, no further step, busy=0, gen_count=1.
5. Single cell 0x0001, single pulse with run=0 -> exactly one step; alive=0x0000, extinct=1, gen_count=1, back to IDLE.
6. Load 0xCC33 while in WAIT after 3 generations -> gen_count=0, flags cleared, write_enb pulse; step resumes period+3 cycles later; first check gives alive=0xC813.
